// File: rtl/tile_pkg.sv
// Shared constants and FSM state encoding for the tile memory block.
package tile_pkg;

   localparam int unsigned CELL_W_DEF   = 4;
   localparam int unsigned EDGE_N_DEF   = 24;
   localparam int unsigned CENTER_N_DEF = 12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_FINISH = 2'd2
   } tile_state_t;

endpackage

// File: rtl/edge_ring_rotate.sv
// Combinational one-cell rotation of the edge ring.
// Cell i occupies ring bits [i*CELL_W +: CELL_W].
//   dir=0 (left):  out[i] = in[(i+1) mod EDGE_N]
//   dir=1 (right): out[i] = in[(i-1) mod EDGE_N]
module edge_ring_rotate
   import tile_pkg::*;
#(
   parameter int unsigned CELL_W = CELL_W_DEF,
   parameter int unsigned EDGE_N = EDGE_N_DEF
) (
   input  logic                     dir,
   input  logic [EDGE_N*CELL_W-1:0] ring_in,
   output logic [EDGE_N*CELL_W-1:0] ring_out
);

   localparam int unsigned RING_W = EDGE_N * CELL_W;

   // Rotate by one cell position in the requested direction.
   always_comb begin
      ring_out = ring_in;
      if (dir) begin
         ring_out = {ring_in[RING_W-CELL_W-1:0], ring_in[RING_W-1 -: CELL_W]};
      end else begin
         ring_out = {ring_in[CELL_W-1:0], ring_in[RING_W-1:CELL_W]};
      end
   end

endmodule

// File: rtl/tile_memory.sv
// Tile cell store: edge ring plus center cells, with bulk load, single-cell
// write, registered read and a multi-step edge-ring rotation engine.
module tile_memory
   import tile_pkg::*;
#(
   parameter int unsigned CELL_W   = CELL_W_DEF,
   parameter int unsigned EDGE_N   = EDGE_N_DEF,
   parameter int unsigned CENTER_N = CENTER_N_DEF,
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned STEP_W   = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       BULK_WR,
   input  logic [EDGE_N*CELL_W-1:0]   EDGE_DATA_IN,
   input  logic [CENTER_N*CELL_W-1:0] CENTER_DATA_IN,
   input  logic                       WR,
   input  logic [ADDR_W-1:0]          WR_ADDR,
   input  logic [CELL_W-1:0]          WR_DATA,
   input  logic [ADDR_W-1:0]          RD_ADDR,
   output logic [CELL_W-1:0]          DATA_OUT,
   input  logic                       ROT_START,
   input  logic                       ROT_DIR,
   input  logic [STEP_W-1:0]          ROT_STEPS,
   output logic                       BUSY,
   output logic                       DONE
);

   localparam int unsigned TOTAL   = EDGE_N + CENTER_N;
   localparam int unsigned RING_W  = EDGE_N * CELL_W;
   localparam logic [ADDR_W:0] TOTAL_A = (ADDR_W + 1)'(TOTAL);

   logic [CELL_W-1:0] cells [TOTAL];
   tile_state_t       state;
   logic [STEP_W-1:0] step_cnt;
   logic              rot_dir;
   logic [RING_W-1:0] ring_cur;
   logic [RING_W-1:0] ring_nxt;
   logic              wr_ok;
   logic              rd_ok;

   // Flatten the edge cells into a ring vector for the rotator.
   always_comb begin
      ring_cur = '0;
      for (int unsigned i = 0; i < EDGE_N; i++) begin
         ring_cur[i*CELL_W +: CELL_W] = cells[i];
      end
   end

   edge_ring_rotate #(
      .CELL_W (CELL_W),
      .EDGE_N (EDGE_N)
   ) u_rot (
      .dir      (rot_dir),
      .ring_in  (ring_cur),
      .ring_out (ring_nxt)
   );

   // Address qualification for single-cell write and read.
   always_comb begin
      wr_ok = WR && !BUSY && ({1'b0, WR_ADDR} < TOTAL_A);
      rd_ok = ({1'b0, RD_ADDR} < TOTAL_A);
   end

   // Rotation controller: latch request, count steps, pulse DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         step_cnt <= '0;
         rot_dir  <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ROT_START && !BULK_WR) begin
                  rot_dir  <= ROT_DIR;
                  step_cnt <= ROT_STEPS;
                  if (ROT_STEPS == '0) begin
                     state <= ST_FINISH;
                     DONE  <= 1'b1;
                  end else begin
                     state <= ST_ROTATE;
                     BUSY  <= 1'b1;
                  end
               end
            end
            ST_ROTATE: begin
               if (BULK_WR) begin
                  state    <= ST_IDLE;
                  BUSY     <= 1'b0;
                  step_cnt <= '0;
               end else begin
                  step_cnt <= step_cnt - STEP_W'(1);
                  if (step_cnt == STEP_W'(1)) begin
                     state <= ST_FINISH;
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                  end
               end
            end
            ST_FINISH: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

   // Cell store update: reset > bulk load > rotation step > single write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < TOTAL; i++) begin
            cells[i] <= '0;
         end
      end else if (BULK_WR) begin
         for (int unsigned i = 0; i < EDGE_N; i++) begin
            cells[i] <= EDGE_DATA_IN[(EDGE_N-i)*CELL_W-1 -: CELL_W];
         end
         for (int unsigned j = 0; j < CENTER_N; j++) begin
            cells[EDGE_N+j] <= CENTER_DATA_IN[(CENTER_N-j)*CELL_W-1 -: CELL_W];
         end
      end else if (state == ST_ROTATE) begin
         for (int unsigned i = 0; i < EDGE_N; i++) begin
            cells[i] <= ring_nxt[i*CELL_W +: CELL_W];
         end
      end else if (wr_ok) begin
         cells[WR_ADDR] <= WR_DATA;
      end
   end

   // Registered read of pre-edge contents; out-of-range reads return 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         DATA_OUT <= '0;
      end else if (rd_ok) begin
         DATA_OUT <= cells[RD_ADDR];
      end else begin
         DATA_OUT <= '0;
      end
   end

endmodule

// File: tb/tb_tile_memory.sv
// Directed self-checking bench for tile_memory.
module tb_tile_memory;

   localparam int CELL_W   = 4;
   localparam int EDGE_N   = 24;
   localparam int CENTER_N = 12;
   localparam int ADDR_W   = 6;
   localparam int STEP_W   = 5;

   localparam logic [EDGE_N*CELL_W-1:0]   PAT_A = 96'h0123456789ABCDEF01234567;
   localparam logic [CENTER_N*CELL_W-1:0] CEN_A = 48'hAAAAAAAAAAAA;
   localparam logic [EDGE_N*CELL_W-1:0]   PAT_B = 96'hFEDCBA9876543210FEDCBA98;
   localparam logic [CENTER_N*CELL_W-1:0] CEN_B = 48'h333333333333;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       BULK_WR;
   logic [EDGE_N*CELL_W-1:0]   EDGE_DATA_IN;
   logic [CENTER_N*CELL_W-1:0] CENTER_DATA_IN;
   logic                       WR;
   logic [ADDR_W-1:0]          WR_ADDR;
   logic [CELL_W-1:0]          WR_DATA;
   logic [ADDR_W-1:0]          RD_ADDR;
   logic [CELL_W-1:0]          DATA_OUT;
   logic                       ROT_START;
   logic                       ROT_DIR;
   logic [STEP_W-1:0]          ROT_STEPS;
   logic                       BUSY;
   logic                       DONE;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   tile_memory #(
      .CELL_W   (CELL_W),
      .EDGE_N   (EDGE_N),
      .CENTER_N (CENTER_N),
      .ADDR_W   (ADDR_W),
      .STEP_W   (STEP_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .BULK_WR        (BULK_WR),
      .EDGE_DATA_IN   (EDGE_DATA_IN),
      .CENTER_DATA_IN (CENTER_DATA_IN),
      .WR             (WR),
      .WR_ADDR        (WR_ADDR),
      .WR_DATA        (WR_DATA),
      .RD_ADDR        (RD_ADDR),
      .DATA_OUT       (DATA_OUT),
      .ROT_START      (ROT_START),
      .ROT_DIR        (ROT_DIR),
      .ROT_STEPS      (ROT_STEPS),
      .BUSY           (BUSY),
      .DONE           (DONE)
   );

   // Set read address on the falling edge, return 1ns after the next rising edge.
   task automatic rd(input logic [ADDR_W-1:0] a);
      @(negedge clk);
      RD_ADDR = a;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; BULK_WR = 1'b0; EDGE_DATA_IN = '0; CENTER_DATA_IN = '0;
      WR = 1'b0; WR_ADDR = '0; WR_DATA = '0; RD_ADDR = '0;
      ROT_START = 1'b0; ROT_DIR = 1'b0; ROT_STEPS = '0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", BUSY); end
      tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", DONE); end
      tests++; if (DATA_OUT !== 4'h0) begin fails++; $display("FAIL reset_dout: got %h want 0", DATA_OUT); end
      @(negedge clk); rst = 1'b0;
      rd(6'd0);
      tests++; if (DATA_OUT !== 4'h0) begin fails++; $display("FAIL reset_cell0: got %h want 0", DATA_OUT); end
      rd(6'd30);
      tests++; if (DATA_OUT !== 4'h0) begin fails++; $display("FAIL reset_cell30: got %h want 0", DATA_OUT); end
   endtask

   task automatic test_bulk_load;
      @(negedge clk);
      EDGE_DATA_IN = PAT_A; CENTER_DATA_IN = CEN_A; BULK_WR = 1'b1;
      @(negedge clk); BULK_WR = 1'b0;
      rd(6'd1);
      tests++; if (DATA_OUT !== 4'h1) begin fails++; $display("FAIL bulk_addr1: got %h want 1", DATA_OUT); end
      rd(6'd23);
      tests++; if (DATA_OUT !== 4'h7) begin fails++; $display("FAIL bulk_addr23: got %h want 7", DATA_OUT); end
      rd(6'd30);
      tests++; if (DATA_OUT !== 4'hA) begin fails++; $display("FAIL bulk_addr30: got %h want a", DATA_OUT); end
      rd(6'd15);
      tests++; if (DATA_OUT !== 4'hF) begin fails++; $display("FAIL bulk_addr15: got %h want f", DATA_OUT); end
      rd(6'd35);
      tests++; if (DATA_OUT !== 4'hA) begin fails++; $display("FAIL bulk_addr35: got %h want a", DATA_OUT); end
   endtask

   task automatic test_single_write;
      @(negedge clk); WR = 1'b1; WR_ADDR = 6'd5; WR_DATA = 4'hF;
      @(negedge clk); WR = 1'b0;
      rd(6'd5);
      tests++; if (DATA_OUT !== 4'hF) begin fails++; $display("FAIL wr_addr5: got %h want f", DATA_OUT); end
      rd(6'd4);
      tests++; if (DATA_OUT !== 4'h4) begin fails++; $display("FAIL wr_neighbor4: got %h want 4", DATA_OUT); end
      // Read and write the same cell in one cycle: old value must come back.
      @(negedge clk); RD_ADDR = 6'd6; WR = 1'b1; WR_ADDR = 6'd6; WR_DATA = 4'h3;
      @(posedge clk); #1;
      tests++; if (DATA_OUT !== 4'h6) begin fails++; $display("FAIL rbw_old: got %h want 6", DATA_OUT); end
      @(negedge clk); WR = 1'b0;
      rd(6'd6);
      tests++; if (DATA_OUT !== 4'h3) begin fails++; $display("FAIL rbw_new: got %h want 3", DATA_OUT); end
      @(negedge clk); WR = 1'b1; WR_ADDR = 6'd40; WR_DATA = 4'h5;
      @(negedge clk); WR = 1'b0;
      rd(6'd40);
      tests++; if (DATA_OUT !== 4'h0) begin fails++; $display("FAIL wr_oor40: got %h want 0", DATA_OUT); end
      rd(6'd35);
      tests++; if (DATA_OUT !== 4'hA) begin fails++; $display("FAIL wr_oor_noalias: got %h want a", DATA_OUT); end
   endtask

   task automatic test_rotation;
      int busy_cycles;
      int done_cycle;
      int done_count;
      busy_cycles = 0; done_cycle = 0; done_count = 0;
      @(negedge clk); ROT_START = 1'b1; ROT_DIR = 1'b0; ROT_STEPS = 5'd3;
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); #1;
         ROT_START = 1'b0;
         if (BUSY) busy_cycles++;
         if (DONE) begin
            done_count++;
            if (done_cycle == 0) done_cycle = c;
         end
      end
      tests++; if (busy_cycles != 3) begin fails++; $display("FAIL rot_busy_cycles: got %0d want 3", busy_cycles); end
      tests++; if (done_cycle != 4) begin fails++; $display("FAIL rot_done_cycle: got %0d want 4", done_cycle); end
      tests++; if (done_count != 1) begin fails++; $display("FAIL rot_done_count: got %0d want 1", done_count); end
      rd(6'd0);
      tests++; if (DATA_OUT !== 4'h3) begin fails++; $display("FAIL rot_edge0: got %h want 3", DATA_OUT); end
      rd(6'd21);
      tests++; if (DATA_OUT !== 4'h0) begin fails++; $display("FAIL rot_edge21: got %h want 0", DATA_OUT); end
      rd(6'd2);
      tests++; if (DATA_OUT !== 4'hF) begin fails++; $display("FAIL rot_edge2: got %h want f", DATA_OUT); end
      rd(6'd23);
      tests++; if (DATA_OUT !== 4'h2) begin fails++; $display("FAIL rot_edge23: got %h want 2", DATA_OUT); end
      rd(6'd30);
      tests++; if (DATA_OUT !== 4'hA) begin fails++; $display("FAIL rot_center30: got %h want a", DATA_OUT); end
   endtask

   task automatic test_zero_step;
      @(negedge clk); ROT_START = 1'b1; ROT_DIR = 1'b1; ROT_STEPS = 5'd0;
      @(posedge clk); #1;
      ROT_START = 1'b0;
      tests++; if (DONE !== 1'b1) begin fails++; $display("FAIL zero_done: got %b want 1", DONE); end
      tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL zero_busy: got %b want 0", BUSY); end
      @(posedge clk); #1;
      tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL zero_done_drop: got %b want 0", DONE); end
      tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL zero_busy2: got %b want 0", BUSY); end
      rd(6'd0);
      tests++; if (DATA_OUT !== 4'h3) begin fails++; $display("FAIL zero_edge0: got %h want 3", DATA_OUT); end
      rd(6'd21);
      tests++; if (DATA_OUT !== 4'h0) begin fails++; $display("FAIL zero_edge21: got %h want 0", DATA_OUT); end
   endtask

   task automatic test_abort_guard;
      int stray;
      stray = 0;
      @(negedge clk); ROT_START = 1'b1; ROT_DIR = 1'b1; ROT_STEPS = 5'd5;
      @(posedge clk); #1;
      tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL abort_busy_start: got %b want 1", BUSY); end
      @(negedge clk); ROT_START = 1'b0; WR = 1'b1; WR_ADDR = 6'd30; WR_DATA = 4'h1; RD_ADDR = 6'd30;
      @(posedge clk); #1;
      tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL abort_busy_step1: got %b want 1", BUSY); end
      @(negedge clk); WR = 1'b0; BULK_WR = 1'b1; EDGE_DATA_IN = PAT_B; CENTER_DATA_IN = CEN_B;
      @(posedge clk); #1;
      tests++; if (DATA_OUT !== 4'hA) begin fails++; $display("FAIL guard_wr_busy: got %h want a", DATA_OUT); end
      tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", BUSY); end
      tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL abort_done: got %b want 0", DONE); end
      @(negedge clk); BULK_WR = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (DONE || BUSY) stray++;
      end
      tests++; if (stray != 0) begin fails++; $display("FAIL abort_idle: got %0d busy/done cycles want 0", stray); end
      rd(6'd0);
      tests++; if (DATA_OUT !== 4'hF) begin fails++; $display("FAIL abort_edge0: got %h want f", DATA_OUT); end
      rd(6'd1);
      tests++; if (DATA_OUT !== 4'hE) begin fails++; $display("FAIL abort_edge1: got %h want e", DATA_OUT); end
      rd(6'd23);
      tests++; if (DATA_OUT !== 4'h8) begin fails++; $display("FAIL abort_edge23: got %h want 8", DATA_OUT); end
      rd(6'd30);
      tests++; if (DATA_OUT !== 4'h3) begin fails++; $display("FAIL abort_center30: got %h want 3", DATA_OUT); end
   endtask

   task automatic test_rotate_right;
      @(negedge clk); ROT_START = 1'b1; ROT_DIR = 1'b1; ROT_STEPS = 5'd1;
      @(posedge clk); #1;
      ROT_START = 1'b0;
      tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL right_busy: got %b want 1", BUSY); end
      @(posedge clk); #1;
      tests++; if (DONE !== 1'b1) begin fails++; $display("FAIL right_done: got %b want 1", DONE); end
      rd(6'd0);
      tests++; if (DATA_OUT !== 4'h8) begin fails++; $display("FAIL right_edge0: got %h want 8", DATA_OUT); end
      rd(6'd1);
      tests++; if (DATA_OUT !== 4'hF) begin fails++; $display("FAIL right_edge1: got %h want f", DATA_OUT); end
      rd(6'd23);
      tests++; if (DATA_OUT !== 4'h9) begin fails++; $display("FAIL right_edge23: got %h want 9", DATA_OUT); end
      rd(6'd24);
      tests++; if (DATA_OUT !== 4'h3) begin fails++; $display("FAIL right_center24: got %h want 3", DATA_OUT); end
   endtask

   task automatic test_reset_mid_rotation;
      int stray;
      stray = 0;
      @(negedge clk); ROT_START = 1'b1; ROT_DIR = 1'b0; ROT_STEPS = 5'd5; RD_ADDR = 6'd1;
      @(posedge clk); #1;
      ROT_START = 1'b0;
      @(posedge clk); #1;
      tests++; if (BUSY !== 1'b1) begin fails++; $display("FAIL rstmid_busy_pre: got %b want 1", BUSY); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", BUSY); end
      tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL rstmid_done: got %b want 0", DONE); end
      tests++; if (DATA_OUT !== 4'h0) begin fails++; $display("FAIL rstmid_dout: got %h want 0", DATA_OUT); end
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (DONE || BUSY) stray++;
      end
      tests++; if (stray != 0) begin fails++; $display("FAIL rstmid_idle: got %0d busy/done cycles want 0", stray); end
      rd(6'd0);
      tests++; if (DATA_OUT !== 4'h0) begin fails++; $display("FAIL rstmid_edge0: got %h want 0", DATA_OUT); end
      rd(6'd23);
      tests++; if (DATA_OUT !== 4'h0) begin fails++; $display("FAIL rstmid_edge23: got %h want 0", DATA_OUT); end
      rd(6'd30);
      tests++; if (DATA_OUT !== 4'h0) begin fails++; $display("FAIL rstmid_center30: got %h want 0", DATA_OUT); end
   endtask

   initial begin
      test_reset();
      test_bulk_load();
      test_single_write();
      test_rotation();
      test_zero_step();
      test_abort_guard();
      test_rotate_right();
      test_reset_mid_rotation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
      $fatal(1);
   end

endmodule
